// File: rtl/hack_memory.sv
// hack_memory: Hack computer data memory.
// 16K-word general RAM, 8K-word screen buffer and a read-only keyboard
// register mapped into a 15-bit word address space.  Reads are combinational,
// writes happen on the rising clock edge.
// Optional feature macro: HACK_MEMORY_KEYBOARD_EN adds the live kbd input
// returned at address 0x6000; without it that address reads as zero.
module hack_memory (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic [14:0] address,
    input  logic        load,
`ifdef HACK_MEMORY_KEYBOARD_EN
    input  logic [15:0] kbd,
`endif
    output logic [15:0] out
);

    localparam int RamWords    = 16384;
    localparam int ScreenWords = 8192;
    localparam logic [14:0] KbdAddr = 15'h6000;

    logic [15:0] ramMem    [RamWords];
    logic [15:0] screenMem [ScreenWords];

    logic        selRam;
    logic        selScreen;
    logic        selKbd;
    logic [15:0] kbdValue;

    // Region decode: bit 14 clear is RAM, 2'b10 in bits 14:13 is the screen,
    // and only the exact address 0x6000 reaches the keyboard.
    always_comb begin
        selRam    = (address[14] == 1'b0);
        selScreen = (address[14:13] == 2'b10);
        selKbd    = (address == KbdAddr);
    end

`ifdef HACK_MEMORY_KEYBOARD_EN
    assign kbdValue = kbd;
`else
    assign kbdValue = 16'h0000;
`endif

    // Storage write port; contents survive reset, but an asserted reset
    // at the edge suppresses the write so no word changes.
    always_ff @(posedge clk) begin
        if (rst_n && load) begin
            if (selRam) begin
                ramMem[address[13:0]] <= in;
            end
            if (selScreen) begin
                screenMem[address[12:0]] <= in;
            end
        end
    end

    // Combinational read mux; reset forces zero immediately, and the
    // keyboard and unmapped space never read from storage.
    always_comb begin
        out = 16'h0000;
        if (rst_n) begin
            if (selRam) begin
                out = ramMem[address[13:0]];
            end else if (selScreen) begin
                out = screenMem[address[12:0]];
            end else if (selKbd) begin
                out = kbdValue;
            end
        end
    end

endmodule

// File: tb/tb_hack_memory.sv
// tb_hack_memory: randomized and directed self-checking bench for hack_memory.
// Honors HACK_MEMORY_KEYBOARD_EN in the same way as the design.
module tb_hack_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [14:0] address;
    logic        load;
    logic [15:0] out;
`ifdef HACK_MEMORY_KEYBOARD_EN
    logic [15:0] kbd;
`endif

    int checkCount;
    int passCount;
    bit checkEnable;

    // Flat picture of the whole 32K address space: one word per address,
    // plus a flag telling whether the word has been written since power-up.
    logic [15:0] mdl   [32768];
    bit          known [32768];

    hack_memory dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .address (address),
        .load    (load),
`ifdef HACK_MEMORY_KEYBOARD_EN
        .kbd     (kbd),
`endif
        .out     (out)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit isStorage(input logic [14:0] a);
        return (a < 15'h6000);
    endfunction

    function automatic logic [15:0] modelRead(input logic [14:0] a);
        if (!rst_n) return 16'h0000;
        if (isStorage(a)) return mdl[a];
        if (a == 15'h6000) begin
`ifdef HACK_MEMORY_KEYBOARD_EN
            return kbd;
`else
            return 16'h0000;
`endif
        end
        return 16'h0000;
    endfunction

    // Reference write behaviour: a word in RAM or screen takes the data
    // when load is high and reset is released at the rising edge.
    always @(posedge clk) begin
        if (checkEnable && rst_n === 1'b1 && load === 1'b1 && isStorage(address)) begin
            mdl[address]   <= in;
            known[address] <= 1'b1;
        end
    end

    // Every-cycle comparison of the read port, skipping never-written words.
    always @(negedge clk) begin
        if (checkEnable) begin
            if (!(rst_n && isStorage(address) && !known[address])) begin
                checkCount++;
                if (out !== modelRead(address)) begin
                    $display("[TB] FAIL cycleCompare addr=%h actual=%h required=%h rst_n=%b",
                             address, out, modelRead(address), rst_n);
                end else begin
                    passCount++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [15:0] d,
                                 input logic [14:0] a, input logic l);
        @(posedge clk);
        #2;
        rst_n   = r;
        in      = d;
        address = a;
        load    = l;
        checkEnable = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expected);
        @(negedge clk);
        #1;
        checkCount++;
        if (out !== expected) begin
            $display("[TB] FAIL %s actual=%h required=%h", name, out, expected);
        end else begin
            passCount++;
        end
    endtask

    function automatic logic [14:0] randomAddress();
        logic [14:0] base;
        case ($urandom_range(0, 7))
            0: base = 15'h0000;
            1: base = 15'h1000;
            2: base = 15'h3000;
            3: base = 15'h4000;
            4: base = 15'h5000;
            5: base = 15'h7000;
            6: base = 15'h6000;
            default: base = 15'h2000;
        endcase
        return base + 15'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [15:0] kbdExpected;
        checkCount  = 0;
        passCount   = 0;
        checkEnable = 1'b0;
        rst_n   = 1'b0;
        in      = 16'h0000;
        address = 15'h0000;
        load    = 1'b0;
`ifdef HACK_MEMORY_KEYBOARD_EN
        kbd = 16'h0041;
        kbdExpected = 16'h0041;
`else
        kbdExpected = 16'h0000;
`endif

        // Write attempt while in reset is blocked and out reads zero.
        applyStimulus(1'b0, 16'h00FF, 15'h00FF, 1'b1);
        checkOutput("resetOutZero", 16'h0000);
        applyStimulus(1'b1, 16'h00FF, 15'h00FF, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 15'h00FF, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 15'h00FF, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 15'h00FF, 1'b0);
        checkOutput("ramWrite00FF", 16'h00FF);

        // Screen write leaves RAM untouched.
        applyStimulus(1'b1, 16'hFFFF, 15'h50FF, 1'b1);
        applyStimulus(1'b1, 16'hFFFF, 15'h50FF, 1'b0);
        checkOutput("screenWrite50FF", 16'hFFFF);
        applyStimulus(1'b1, 16'h0000, 15'h00FF, 1'b0);
        checkOutput("ramAfterScreen", 16'h00FF);

        // Seed two RAM words used later to detect aliasing.
        applyStimulus(1'b1, 16'h1234, 15'h1000, 1'b1);
        applyStimulus(1'b1, 16'h5678, 15'h10F0, 1'b1);

        // Keyboard address is read-only.
        applyStimulus(1'b1, 16'hFF12, 15'h6000, 1'b1);
        checkOutput("kbdBeforeEdge", kbdExpected);
        applyStimulus(1'b1, 16'hFF12, 15'h6000, 1'b1);
        checkOutput("kbdAfterEdge", kbdExpected);

        // Unmapped writes are dropped and do not alias into RAM.
        applyStimulus(1'b1, 16'hFF12, 15'h7000, 1'b1);
        checkOutput("unmapped7000", 16'h0000);
        applyStimulus(1'b1, 16'hFF12, 15'h70F0, 1'b1);
        checkOutput("unmapped70F0", 16'h0000);
        applyStimulus(1'b1, 16'h0000, 15'h1000, 1'b0);
        checkOutput("noAlias1000", 16'h1234);
        applyStimulus(1'b1, 16'h0000, 15'h10F0, 1'b0);
        checkOutput("noAlias10F0", 16'h5678);

        // Region boundaries.
        applyStimulus(1'b1, 16'hA1A1, 15'h3FFF, 1'b1);
        applyStimulus(1'b1, 16'hB2B2, 15'h4000, 1'b1);
        applyStimulus(1'b1, 16'hC3C3, 15'h5FFF, 1'b1);
        applyStimulus(1'b1, 16'hD4D4, 15'h0000, 1'b1);
        applyStimulus(1'b1, 16'h0000, 15'h3FFF, 1'b0);
        checkOutput("bound3FFF", 16'hA1A1);
        applyStimulus(1'b1, 16'h0000, 15'h4000, 1'b0);
        checkOutput("bound4000", 16'hB2B2);
        applyStimulus(1'b1, 16'h0000, 15'h5FFF, 1'b0);
        checkOutput("bound5FFF", 16'hC3C3);
        applyStimulus(1'b1, 16'h0000, 15'h0000, 1'b0);
        checkOutput("bound0000", 16'hD4D4);
        applyStimulus(1'b1, 16'h0000, 15'h6001, 1'b0);
        checkOutput("unmapped6001", 16'h0000);

        // Reset pulse across an edge while a write is requested.
        applyStimulus(1'b1, 16'h1111, 15'h0010, 1'b1);
        applyStimulus(1'b0, 16'hBEEF, 15'h0010, 1'b1);
        checkOutput("duringReset", 16'h0000);
        applyStimulus(1'b1, 16'hBEEF, 15'h0010, 1'b1);
        checkOutput("afterReleaseOld", 16'h1111);
        applyStimulus(1'b1, 16'hBEEF, 15'h0010, 1'b0);
        checkOutput("afterReleaseNew", 16'hBEEF);

        // Randomized traffic across all regions with occasional resets.
        for (int i = 0; i < 600; i++) begin
`ifdef HACK_MEMORY_KEYBOARD_EN
            kbd = 16'($urandom);
`endif
            applyStimulus(($urandom_range(0, 39) != 0), 16'($urandom),
                          randomAddress(), 1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b1, 16'h0000, 15'h0000, 1'b0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
